// File: rtl/tx_ram_rd_ctrl.sv
// Read-side controller for the TX distributed SDPRAM: pointer sync, RAM read, output register, framing check.
// Optional mid-frame starvation counter enabled with `define TX_RD_UNDERRUN_CNT_EN.
module tx_ram_rd_ctrl #(
  parameter int ADDR_WIDTH  = 4,
  parameter int DATA_WIDTH  = 70,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   wr_ptr_gray,
  output logic [ADDR_WIDTH:0]   rd_ptr_gray,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH:0]   fill_level,
  output logic                  frame_err
`ifdef TX_RD_UNDERRUN_CNT_EN
  ,
  input  logic                  underrun_clr,
  output logic [15:0]           underrun_cnt
`endif
);

  // state | meaning
  // IDLE  | between frames, next loaded word must carry sof
  // FRAME | inside a frame, waiting for the word carrying eof
  typedef enum logic {IDLE, FRAME} state_t;

  localparam int SOF_BIT = 64;
  localparam int EOF_BIT = 65;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
    logic [ADDR_WIDTH:0] b;
    b[ADDR_WIDTH] = g[ADDR_WIDTH];
    for (int i = ADDR_WIDTH - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [ADDR_WIDTH:0] sync_q [SYNC_STAGES];
  logic [ADDR_WIDTH:0] wr_ptr_s;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                empty;
  logic                load;
  state_t              state, state_nxt;
  logic                frame_err_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= wr_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign wr_ptr_s = gray2bin(sync_q[SYNC_STAGES-1]);
  assign empty    = (wr_ptr_s == rd_ptr);
  assign load     = !empty && (!out_valid || out_ready);
  assign rd_addr  = rd_ptr[ADDR_WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      rd_ptr_gray <= '0;
      fill_level  <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
    end else begin
      rd_ptr_gray <= rd_ptr ^ (rd_ptr >> 1);
      fill_level  <= wr_ptr_s - rd_ptr;
      if (load) begin
        out_data  <= rd_data;
        out_valid <= 1'b1;
        rd_ptr    <= rd_ptr + PTR_ONE;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      frame_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      frame_err <= frame_err_nxt;
    end
  end

  // A stray sof inside a frame restarts the frame rather than closing it.
  always_comb begin
    state_nxt     = state;
    frame_err_nxt = 1'b0;
    if (load) begin
      case (state)
        IDLE: begin
          if (!rd_data[SOF_BIT]) frame_err_nxt = 1'b1;
          else if (!rd_data[EOF_BIT]) state_nxt = FRAME;
        end
        FRAME: begin
          if (rd_data[SOF_BIT]) frame_err_nxt = 1'b1;
          if (rd_data[EOF_BIT]) state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef TX_RD_UNDERRUN_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      underrun_cnt <= '0;
    end else if (underrun_clr) begin
      underrun_cnt <= '0;
    end else if (state == FRAME && empty && (!out_valid || out_ready) &&
                 underrun_cnt != 16'hFFFF) begin
      underrun_cnt <= underrun_cnt + 16'd1;
    end
  end
`else
  // Starvation counter not built.
`endif

endmodule

// File: tb/tb_tx_ram_rd_ctrl.sv
// Randomised bench for tx_ram_rd_ctrl: RAM/writer model, word scoreboard and framing reference.
// Define TX_RD_UNDERRUN_CNT_EN to also exercise the starvation counter.
module tb_tx_ram_rd_ctrl;
  localparam int AW = 4;
  localparam int DW = 70;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW:0]   wr_ptr_gray;
  logic [AW:0]   rd_ptr_gray;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic [AW:0]   fill_level;
  logic          frame_err;
`ifdef TX_RD_UNDERRUN_CNT_EN
  logic          underrun_clr;
  logic [15:0]   underrun_cnt;
`endif

  always #5 clk = ~clk;

  tx_ram_rd_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_ptr_gray(wr_ptr_gray), .rd_ptr_gray(rd_ptr_gray),
    .rd_addr(rd_addr), .rd_data(rd_data), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill_level(fill_level), .frame_err(frame_err)
`ifdef TX_RD_UNDERRUN_CNT_EN
    , .underrun_clr(underrun_clr), .underrun_cnt(underrun_cnt)
`endif
  );

  logic [DW-1:0] ram [16];
  assign rd_data = ram[rd_addr];

  int n_chk = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q [$];
  bit            err_q [$];
  int  wp = 0;
  int  n_pop = 0;
  bit  in_frame = 1'b0;
  bit  fresh = 1'b1;
  int  wraps = 0;
  logic [AW-1:0] last_addr = '0;

  task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] bin2gray(input logic [AW:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic bit space();
    return (wp - n_pop) < 16;
  endfunction

  function automatic logic [DW-1:0] rnd_word();
    logic [DW-1:0] w;
    w = '0;
    w[31:0]  = $urandom;
    w[63:32] = $urandom;
    w[64]    = ($urandom_range(0, 2) == 0);
    w[65]    = ($urandom_range(0, 2) == 0);
    w[68:66] = 3'($urandom_range(0, 7));
    return w;
  endfunction

  // Writer side: store word, derive its expected framing error, publish the gray pointer.
  task automatic write_word(input logic [DW-1:0] w);
    bit sof, eof, err;
    sof = w[64];
    eof = w[65];
    if (!in_frame) begin
      err = !sof;
      in_frame = sof && !eof;
    end else begin
      err = sof;
      in_frame = !eof;
    end
    ram[wp % 16] = w;
    exp_q.push_back(w);
    err_q.push_back(err);
    wp++;
    wr_ptr_gray = bin2gray(5'(wp));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (out_valid) begin
      if (exp_q.size() == 0) chk("spurious_valid", out_valid, 0);
      else begin
        chk("out_data", out_data, exp_q[0]);
        chk("frame_err", frame_err, fresh ? err_q[0] : 1'b0);
      end
    end else begin
      chk("frame_err_idle", frame_err, 0);
    end
    chk("fill_max", fill_level <= 16, 1);
    if (rd_addr == 0 && last_addr == 15) wraps++;
    last_addr = rd_addr;
  endtask

  task automatic drive(input bit rdy, input bit wr, input logic [DW-1:0] w);
    if (wr) write_word(w);
    out_ready = rdy;
    if (out_valid && rdy && exp_q.size() > 0) begin
      void'(exp_q.pop_front());
      void'(err_q.pop_front());
      n_pop++;
      fresh = 1'b1;
    end else if (out_valid) begin
      fresh = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] w1;
    logic [DW-1:0] wf;
    int vcnt, first_v, last_v, pulses, pop0;
    bit wr;

    rst_n = 1'b0;
    wr_ptr_gray = '0;
    out_ready = 1'b0;
`ifdef TX_RD_UNDERRUN_CNT_EN
    underrun_clr = 1'b0;
`endif
    for (int i = 0; i < 16; i++) ram[i] = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    step();
    chk("rst_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_rd_ptr_gray", rd_ptr_gray, 0);
    chk("rst_fill", fill_level, 0);

    // Single-word frame: visible 3 cycles after the pointer moves.
    w1 = '0;
    w1[63:0] = 64'hA5A5_0000_0000_0001;
    w1[64] = 1'b1;
    w1[65] = 1'b1;
    drive(1, 1, w1);
    step(); chk("single_n1_valid", out_valid, 0); drive(1, 0, '0);
    step(); chk("single_n2_valid", out_valid, 0); drive(1, 0, '0);
    step();
    chk("single_n3_valid", out_valid, 1);
    chk("single_n3_data", out_data, w1);
    chk("single_n3_err", frame_err, 0);
    drive(1, 0, '0);
    step();
    chk("single_n4_gray", rd_ptr_gray, 1);
    drive(1, 0, '0);

    // Backpressure: four pending words, stalled reader, then 1/clk drain.
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, rnd_word());
      step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, '0);
      step();
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_rd_addr", rd_addr, (n_pop + 1) % 16);
      chk("bp_fill", fill_level, wp - (n_pop + 1));
      drive(0, 0, '0);
      step();
    end
    drive(1, 0, '0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_drain_valid", out_valid, 1);
      drive(1, 0, '0);
    end
    step();
    chk("bp_drain_done", out_valid, 0);
    drive(1, 0, '0);

    // Streaming 40 words through two address wraps.
    wraps = 0; vcnt = 0; first_v = -1; last_v = -1; wf = '0;
    begin
      int written = 0;
      for (int cyc = 0; cyc < 200 && vcnt < 40; cyc++) begin
        wr = (written < 40) && space();
        drive(1, wr, rnd_word());
        if (wr) written++;
        step();
        if (out_valid) begin
          vcnt++;
          if (first_v < 0) first_v = cyc;
          last_v = cyc;
        end
      end
    end
    chk("stream_count", vcnt, 40);
    chk("stream_gapless", last_v - first_v + 1, 40);
    chk("stream_wraps", wraps, 2);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      wr = ($urandom_range(0, 1) == 1) && space();
      drive($urandom_range(0, 3) != 0, wr, rnd_word());
      step();
    end

    // Reset while a word is held.
    for (int i = 0; i < 50 && !out_valid; i++) begin
      drive(0, space(), rnd_word());
      step();
    end
    chk("rst_pre_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_rd_addr", rd_addr, 0);
    chk("midrst_gray", rd_ptr_gray, 0);
    chk("midrst_fill", fill_level, 0);
    exp_q.delete(); err_q.delete();
    wp = 0; n_pop = 0; in_frame = 1'b0; fresh = 1'b1;
    wr_ptr_gray = '0;
    out_ready = 1'b1;
    #2 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("postrst_rd_addr", rd_addr, 0);
      chk("postrst_gray", rd_ptr_gray, 0);
      drive(1, 0, '0);
    end

    // Framing: sof, data, sof, eof -> one error on the second sof.
    pop0 = n_pop; pulses = 0;
    for (int i = 0; i < 4; i++) begin
      wf = rnd_word();
      wf[64] = (i == 0 || i == 2);
      wf[65] = (i == 3);
      drive(1, 1, wf);
      step();
      if (frame_err) pulses++;
    end
    for (int i = 0; i < 8; i++) begin
      drive(1, 0, '0);
      step();
      if (frame_err) pulses++;
    end
    chk("frame_err_count", pulses, 1);
    chk("frame_forwarded", n_pop - pop0, 4);

`ifdef TX_RD_UNDERRUN_CNT_EN
    drive(1, 0, '0);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("underrun_clr0", underrun_cnt, 0);
    wf = '0; wf[64] = 1'b1;
    drive(1, 1, wf);
    step();
    for (int i = 0; i < 7; i++) begin
      drive(1, 0, '0);
      step();
    end
    wf = '0; wf[65] = 1'b1;
    drive(1, 1, wf);
    for (int i = 0; i < 4; i++) begin
      step();
      drive(1, 0, '0);
    end
    chk("underrun_cnt7", underrun_cnt, 7);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    chk("underrun_clr1", underrun_cnt, 0);
`endif

    for (int i = 0; i < 100 && (exp_q.size() > 0 || out_valid); i++) begin
      drive(1, 0, '0);
      step();
    end
    chk("drain_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/tx_ram_rd_ctrl.md
Name: tx_ram_rd_ctrl

Overview:
- Read-side controller for the 16x70 TX distributed SDPRAM in the raw 10G link TX path.
- Runs in the transceiver TX clock domain.
- Synchronises the gray-coded write pointer from the write domain, drives the RAM read address, and registers the word read from the RAM.
- Presents that word to the downstream TX encoder with a valid/ready handshake, and returns its own gray-coded read pointer to the write side.

Parameters:
- ADDR_WIDTH, 4, RAM address width; the pointers are ADDR_WIDTH+1 bits wide (the extra MSB is the wrap bit).
- DATA_WIDTH, 70, RAM word width. Word format: [63:0] payload, [64] sof, [65] eof, [68:66] last valid byte index, [69] reserved.
- SYNC_STAGES, 2, number of flops in the write-pointer synchroniser; legal values 2..3.

Ports:
- clk  in  1  TX domain clock; also drives the RAM rd_clk.
- rst_n  in  1  Asynchronous active-low reset.
- wr_ptr_gray  in  ADDR_WIDTH+1  Gray-coded write pointer from the write domain.
- rd_ptr_gray  out  ADDR_WIDTH+1  Gray-coded read pointer, registered, sent to the write domain.
- rd_addr  out  ADDR_WIDTH  RAM read address.
- rd_data  in  DATA_WIDTH  RAM read data; combinational, valid in the same cycle as rd_addr.
- out_data  out  DATA_WIDTH  Registered output word.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  Downstream accepts the word.
- fill_level  out  ADDR_WIDTH+1  Synchronised write pointer minus read pointer, in binary.
- frame_err  out  1  One-cycle pulse on a framing violation.

Behaviour:
- Reset (asynchronous, rst_n low): all registers clear.
  - out_valid=0, out_data=0, rd_ptr=0, rd_ptr_gray=0, rd_addr=0.
  - Synchroniser flops=0, fill_level=0, frame_err=0, state=IDLE.
- Write-pointer synchroniser:
  - wr_ptr_gray passes through SYNC_STAGES flops, then is converted gray-to-binary into wr_ptr_s.
  - A change on wr_ptr_gray at the edge of cycle N is seen in wr_ptr_s at cycle N+SYNC_STAGES.
- Pointers:
  - empty = (wr_ptr_s == rd_ptr).
  - fill_level = wr_ptr_s - rd_ptr, computed modulo 2^(ADDR_WIDTH+1) and registered.
  - rd_addr = rd_ptr[ADDR_WIDTH-1:0], driven combinationally from the pointer register.
  - rd_ptr_gray = bin2gray(rd_ptr), registered; it updates one cycle after rd_ptr.
- Load condition: load = !empty && (!out_valid || out_ready).
- On load:
  - out_data <= rd_data; out_valid <= 1; rd_ptr <= rd_ptr + 1.
  - rd_ptr wraps naturally: 31 -> 0 for ADDR_WIDTH=4.
- When there is no load and out_valid && out_ready: out_valid <= 0.
- While out_valid && !out_ready: out_data and out_valid hold, and rd_ptr does not advance.
- Throughput: 1 word/clk when the RAM is non-empty and out_ready stays high.
- Latency: a write becomes visible as out_valid at cycle N+SYNC_STAGES+1 at the earliest.
- Frame FSM, evaluated on each load:
  - IDLE -> FRAME when the loaded word has sof=1 and eof=0.
  - IDLE -> IDLE when the word has sof=1 and eof=1 (single-word frame).
  - IDLE with sof=0: frame_err pulses; the word is still forwarded; state stays IDLE.
  - FRAME -> IDLE when the word has eof=1.
  - FRAME with sof=1: frame_err pulses; state stays FRAME (the new sof restarts the frame); the word is forwarded.
- The RAM is never full from the reader's view; full detection belongs to the writer. No read is issued when empty.
- Reset mid-frame: all state clears immediately, and the word in flight is discarded.

Optional Feature:
- Macro: TX_RD_UNDERRUN_CNT_EN.
- Defined:
  - Adds output underrun_cnt [15:0] and input underrun_clr.
  - The counter increments, saturating at 16'hFFFF, on each cycle where state=FRAME, empty=1 and (!out_valid || out_ready), i.e. a mid-frame starvation cycle.
  - underrun_clr=1 zeroes the counter; clear has priority over increment.
  - The counter resets to 0.
- Not defined: the port and the counter are absent; there is no other behavioural difference.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, rd_addr=0 and rd_ptr_gray=0 within the same cycle; after release these stay 0 until wr_ptr_gray changes.
- Single word: RAM[0]={sof=1,eof=1,payload=64'hA5A5_0000_0000_0001}, wr_ptr_gray 0->1 at cycle N, out_ready=1 -> out_valid=1 with that word at N+3, rd_ptr_gray=1 at N+4, no frame_err.
- Streaming and wrap: writer fills 40 words sequentially with out_ready=1 -> 40 words out in order with no gaps once primed; rd_addr wraps 15 -> 0 twice; fill_level never exceeds 16.
- Backpressure: 4 words pending; out_ready=0 for 5 cycles -> out_data is held stable and rd_ptr is frozen; on out_ready=1 the remaining words drain 1 per cycle.
- Framing: sequence sof, data, sof (no eof), eof -> frame_err pulses exactly once, on the load of the second sof; all 4 words are forwarded.
- Underrun (macro defined): frame started, writer stalls for 7 cycles before eof -> underrun_cnt=7; pulse underrun_clr -> underrun_cnt=0.
